// File: rtl/lpc_reg_bank.sv
// LPC-side register bank: registered reads, W1C event status, write-lock over a protected window.
// Optional key-sequence unlock FSM is compiled in with `define LPC_REG_UNLOCK_SEQ_EN.
module lpc_reg_bank #(
  parameter int                NUM_REGS    = 32,
  parameter int                ADDR_W      = 8,
  parameter logic [7:0]        ID_VALUE    = 8'h00,
  parameter logic [ADDR_W-1:0] STATUS_ADDR = 8'h05,
  parameter logic [ADDR_W-1:0] LOCK_ADDR   = 8'h06,
  parameter logic [ADDR_W-1:0] KEY_ADDR    = 8'h07,
  parameter logic [ADDR_W-1:0] PROT_LO     = 8'h01,
  parameter logic [ADDR_W-1:0] PROT_HI     = 8'h04
) (
  input  logic              PciReset,
  input  logic              LpcClock,
  input  logic [ADDR_W-1:0] Addr,
  input  logic              Wr,
  input  logic              Rd,
  input  logic [7:0]        DataWr,
  input  logic              Next_Bios_latch,
  input  logic [7:0]        Event_In,
  output logic [7:0]        DataRd,
  output logic              RdValid,
  output logic              WrErr,
  output logic              Locked,
  output logic              Irq,
  output logic              Current_Bios,
  output logic              Next_Bios,
  output logic              Active_Bios
);

  localparam int                IDX_W      = $clog2(NUM_REGS);
  localparam int                BIOS_IDX   = 4;
  localparam logic [ADDR_W-1:0] ID_ADDR    = '0;
  localparam logic [ADDR_W-1:0] BIOS_ADDR  = ADDR_W'(BIOS_IDX);
  localparam logic [7:0]        BIOS_WMASK = 8'hFD;
  localparam logic [ADDR_W:0]   NUM_REGS_L = (ADDR_W+1)'(NUM_REGS);

  logic [7:0]       regs [NUM_REGS];
  logic [7:0]       status;
  logic [7:0]       rd_value;
  logic [7:0]       w1c_mask;
  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic             prot_hit;
  logic             wr_reject;
  logic             wr_ok;
  logic             is_special;
  logic             lock_set;
  logic             unlock;

  assign idx       = Addr[IDX_W-1:0];
  assign in_range  = {1'b0, Addr} < NUM_REGS_L;
  assign prot_hit  = Locked && (Addr >= PROT_LO) && (Addr <= PROT_HI);
  assign wr_reject = Wr && (!in_range || prot_hit);
  assign wr_ok     = Wr && !wr_reject;
  assign lock_set  = wr_ok && (Addr == LOCK_ADDR) && DataWr[0];
  assign w1c_mask  = (wr_ok && (Addr == STATUS_ADDR)) ? DataWr : 8'h00;

`ifdef LPC_REG_UNLOCK_SEQ_EN
  localparam logic [0:0] KEY_IDLE = 1'b0;
  localparam logic [0:0] KEY_ONE  = 1'b1;

  logic [0:0] key_state;
  logic       key_wr;

  assign key_wr     = wr_ok && (Addr == KEY_ADDR);
  assign unlock     = key_wr && Locked && (key_state == KEY_ONE) && (DataWr == 8'hAA);
  assign is_special = (Addr == ID_ADDR) || (Addr == STATUS_ADDR) ||
                      (Addr == LOCK_ADDR) || (Addr == KEY_ADDR);

  // The sequence only runs while locked, so any unlock restarts it cleanly.
  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset)   key_state <= KEY_IDLE;
    else if (!Locked) key_state <= KEY_IDLE;
    else if (key_wr) key_state <= (key_state == KEY_IDLE && DataWr == 8'h55) ? KEY_ONE : KEY_IDLE;
  end
`else
  assign unlock     = 1'b0;
  assign is_special = (Addr == ID_ADDR) || (Addr == STATUS_ADDR) || (Addr == LOCK_ADDR);
`endif

  // NOTE: default first in always_comb so no path leaves rd_value unassigned (no latch).
  always_comb begin
    rd_value = 8'hFF;
    if (in_range) begin
      if (Addr == ID_ADDR)          rd_value = ID_VALUE;
      else if (Addr == STATUS_ADDR) rd_value = status;
      else if (Addr == LOCK_ADDR)   rd_value = {7'b0, Locked};
`ifdef LPC_REG_UNLOCK_SEQ_EN
      else if (Addr == KEY_ADDR)    rd_value = 8'h00;
`endif
      else                          rd_value = regs[idx];
    end
  end

  // NOTE: the register array is small and has architected reset values, so it is reset
  // explicitly; non-blocking assignments keep the same-cycle read returning the old value.
  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
      regs[BIOS_IDX] <= {5'b0, Next_Bios_latch, ~Next_Bios_latch, Next_Bios_latch};
    end else if (wr_ok && !is_special) begin
      if (Addr == BIOS_ADDR) regs[idx] <= (regs[idx] & ~BIOS_WMASK) | (DataWr & BIOS_WMASK);
      else                   regs[idx] <= DataWr;
    end
  end

  // Event set is OR-ed in after the clear so a simultaneous event wins.
  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) status <= 8'h00;
    else           status <= (status & ~w1c_mask) | Event_In;
  end

  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset)     Locked <= 1'b0;
    else if (lock_set) Locked <= 1'b1;
    else if (unlock)   Locked <= 1'b0;
  end

  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      DataRd  <= 8'h00;
      RdValid <= 1'b0;
      WrErr   <= 1'b0;
    end else begin
      RdValid <= Rd;
      WrErr   <= wr_reject;
      if (Rd) DataRd <= rd_value;
    end
  end

  assign Irq          = |status;
  assign Current_Bios = regs[BIOS_IDX][2];
  assign Next_Bios    = regs[BIOS_IDX][1];
  assign Active_Bios  = regs[BIOS_IDX][0];

endmodule
